easyaxi_slv: RTL

AXI read-side slave that accepts AR requests, queues up to OST_DEPTH outstanding requests, and returns R bursts with FIXED, INCR and WRAP address sequencing. It is the read responder paired with the EasyAXI read master in the S01E05 testbench. Read data is a deterministic function of the beat address, so no memory array is needed. It returns SLVERR and DECERR responses for illegal bursts and out-of-range addresses.

---
 rtl/easyaxi_slv_pkg.sv | 64 ++++++
 rtl/easyaxi_slv_if.sv | 39 +++
 rtl/easyaxi_sync_fifo.sv | 77 +++++++
 rtl/easyaxi_slv.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/easyaxi_slv_pkg.sv
// -----------------------------------------------------------------------------
// easyaxi_slv_pkg
//   Shared AXI widths and encodings for the EasyAXI blocks. It also holds the
//   queued AR request record, the registered R beat record, and the rule that
//   decides whether a burst is answered with SLVERR.
// -----------------------------------------------------------------------------
package easyaxi_slv_pkg;

   localparam int AXI_ID_W    = 4;
   localparam int AXI_ADDR_W  = 32;
   localparam int AXI_DATA_W  = 32;
   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_RESP_W  = 2;

   localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;
   localparam logic [AXI_BURST_W-1:0] AXI_BURST_RSVD  = 2'b11;

   localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_1B   = 3'd0;
   localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_2B   = 3'd1;
   localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_4B   = 3'd2;
   localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_8B   = 3'd3;
   localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_16B  = 3'd4;
   localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_32B  = 3'd5;
   localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_64B  = 3'd6;
   localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_128B = 3'd7;

   // One queued read request.
   typedef struct packed {
      logic [AXI_ID_W-1:0]    id;
      logic [AXI_ADDR_W-1:0]  addr;
      logic [AXI_LEN_W-1:0]   len;
      logic [AXI_SIZE_W-1:0]  size;
      logic [AXI_BURST_W-1:0] burst;
   } ar_req_t;

   localparam int AR_REQ_W = $bits(ar_req_t);

   // Registered payload of the R beat currently presented.
   typedef struct packed {
      logic [AXI_DATA_W-1:0] data;
      logic [AXI_RESP_W-1:0] resp;
      logic                  last;
   } r_beat_t;

   // Bursts this slave refuses as a whole: reserved burst type, more than
   // eight beats, or a WRAP whose beat count is not 2, 4 or 8.
   function automatic logic burst_is_illegal(input logic [AXI_BURST_W-1:0] burst,
                                             input logic [AXI_LEN_W-1:0]   len);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7);
      return (burst == AXI_BURST_RSVD) || (len > 8'd7) ||
             ((burst == AXI_BURST_WRAP) && !wrap_len_ok);
   endfunction

endpackage

// File: rtl/easyaxi_slv_if.sv
// -----------------------------------------------------------------------------
// easyaxi_slv_if
//   AXI read channels (AR and R) between the EasyAXI read master and slave.
//   master modport: drives AR payload/valid and rready.
//   slave  modport: drives arready and the R payload/valid.
// -----------------------------------------------------------------------------
interface easyaxi_slv_if;
   import easyaxi_slv_pkg::*;

   logic                   axi_slv_arvalid;
   logic                   axi_slv_arready;
   logic [AXI_ID_W-1:0]    axi_slv_arid;
   logic [AXI_ADDR_W-1:0]  axi_slv_araddr;
   logic [AXI_LEN_W-1:0]   axi_slv_arlen;
   logic [AXI_SIZE_W-1:0]  axi_slv_arsize;
   logic [AXI_BURST_W-1:0] axi_slv_arburst;

   logic                   axi_slv_rvalid;
   logic                   axi_slv_rready;
   logic [AXI_ID_W-1:0]    axi_slv_rid;
   logic [AXI_DATA_W-1:0]  axi_slv_rdata;
   logic [AXI_RESP_W-1:0]  axi_slv_rresp;
   logic                   axi_slv_rlast;

   modport master (
      output axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
             axi_slv_arsize, axi_slv_arburst, axi_slv_rready,
      input  axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
             axi_slv_rresp, axi_slv_rlast
   );

   modport slave (
      input  axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
             axi_slv_arsize, axi_slv_arburst, axi_slv_rready,
      output axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
             axi_slv_rresp, axi_slv_rlast
   );

endinterface

// File: rtl/easyaxi_sync_fifo.sv
// -----------------------------------------------------------------------------
// easyaxi_sync_fifo
//   Single-clock FIFO with full/empty flags. The head entry is always visible
//   on rdata. A push while full and a pop while empty are ignored. A push and
//   a pop in the same cycle are both performed.
//   Ports: clk, rst_n (async, active-low), push/wdata/full, pop/rdata/empty.
// -----------------------------------------------------------------------------
module easyaxi_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4      // power of 2, >= 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (DEPTH == 1) return '0;
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every _d starts as its _q so that no path through the block
      // leaves it unassigned, which would infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: flops use non-blocking assignments so every register samples the
   // pre-edge values of the others, matching the hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset. Entries are only read after a
   // push has written them, and a reset port would stop it mapping to RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/easyaxi_slv.sv
// -----------------------------------------------------------------------------
// easyaxi_slv
//   AXI read slave. AR requests are queued up to OST_DEPTH deep and answered
//   in order. After RD_LAT wait cycles, a burst of len+1 R beats follows, with
//   FIXED/INCR/WRAP address sequencing. The read data is the zero-extended beat
//   address. Illegal bursts answer SLVERR on every beat. Beats at or above
//   ADDR_LIMIT answer DECERR. Error beats carry zero data.
//   Ports: clk, rst_n (async, active-low), axi (easyaxi_slv_if.slave).
// -----------------------------------------------------------------------------
module easyaxi_slv import easyaxi_slv_pkg::*; #(
   parameter int                    OST_DEPTH  = 4,
   parameter int                    RD_LAT     = 2,
   parameter logic [AXI_ADDR_W-1:0] ADDR_LIMIT = 'h100
) (
   input logic         clk,
   input logic         rst_n,
   easyaxi_slv_if.slave axi
);

   localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [AXI_ID_W-1:0]    id_q, id_d;
   logic [AXI_ADDR_W-1:0]  addr_q, addr_d;
   logic [AXI_LEN_W-1:0]   len_q, len_d;
   logic [AXI_SIZE_W-1:0]  size_q, size_d;
   logic [AXI_BURST_W-1:0] burst_q, burst_d;
   logic [AXI_LEN_W-1:0]   beat_q, beat_d;
   logic                   err_q, err_d;
   logic                   rvalid_q, rvalid_d;
   r_beat_t                rbeat_q, rbeat_d;

   ar_req_t                ar_in, ar_head;
   logic                   fifo_full, fifo_empty, fifo_pop;
   logic [AXI_ADDR_W-1:0]  addr_nxt;
   logic [AXI_LEN_W-1:0]   beat_nxt;

   assign ar_in = '{id:    axi.axi_slv_arid,
                    addr:  axi.axi_slv_araddr,
                    len:   axi.axi_slv_arlen,
                    size:  axi.axi_slv_arsize,
                    burst: axi.axi_slv_arburst};

   easyaxi_sync_fifo #(
      .WIDTH (AR_REQ_W),
      .DEPTH (OST_DEPTH)
   ) u_ar_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (axi.axi_slv_arvalid),
      .wdata (ar_in),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .rdata (ar_head),
      .empty (fifo_empty)
   );

   // Address of the beat after 'addr'. WRAP folds back onto the aligned
   // container of (len+1)<<size bytes. Arithmetic truncates at AXI_ADDR_W.
   function automatic logic [AXI_ADDR_W-1:0] next_addr(
      input logic [AXI_ADDR_W-1:0]  addr,
      input logic [AXI_LEN_W-1:0]   len,
      input logic [AXI_SIZE_W-1:0]  size,
      input logic [AXI_BURST_W-1:0] burst);
      logic [AXI_ADDR_W-1:0] step, cont, base, nxt;
      step = AXI_ADDR_W'(1) << size;
      cont = (AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size;
      base = addr & ~(cont - AXI_ADDR_W'(1));
      nxt  = addr + step;
      unique case (burst)
         AXI_BURST_FIXED: return addr;
         AXI_BURST_WRAP:  return (nxt == base + cont) ? base : nxt;
         default:         return nxt;
      endcase
   endfunction

   // Payload for one beat: SLVERR overrides DECERR, which overrides OKAY.
   function automatic r_beat_t make_beat(input logic [AXI_ADDR_W-1:0] addr,
                                         input logic [AXI_LEN_W-1:0]  beat,
                                         input logic [AXI_LEN_W-1:0]  len,
                                         input logic                  err);
      r_beat_t b;
      b.last = (beat == len);
      b.data = '0;
      if (err) begin
         b.resp = AXI_RESP_SLVERR;
      end else if (addr >= ADDR_LIMIT) begin
         b.resp = AXI_RESP_DECERR;
      end else begin
         b.resp = AXI_RESP_OKAY;
         b.data = AXI_DATA_W'(addr);
      end
      return b;
   endfunction

   assign addr_nxt = next_addr(addr_q, len_q, size_q, burst_q);
   assign beat_nxt = beat_q + AXI_LEN_W'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      id_d     = id_q;
      addr_d   = addr_q;
      len_d    = len_q;
      size_d   = size_q;
      burst_d  = burst_q;
      beat_d   = beat_q;
      err_d    = err_q;
      rvalid_d = rvalid_q;
      rbeat_d  = rbeat_q;
      fifo_pop = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               id_d     = ar_head.id;
               addr_d   = ar_head.addr;
               len_d    = ar_head.len;
               size_d   = ar_head.size;
               burst_d  = ar_head.burst;
               beat_d   = '0;
               err_d    = burst_is_illegal(ar_head.burst, ar_head.len);
               if (RD_LAT == 0) begin
                  state_d  = ST_DATA;
                  rvalid_d = 1'b1;
                  rbeat_d  = make_beat(ar_head.addr, '0, ar_head.len, err_d);
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(RD_LAT);
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d  = ST_DATA;
               rvalid_d = 1'b1;
               rbeat_d  = make_beat(addr_q, '0, len_q, err_q);
            end
         end
         ST_DATA: begin
            // The payload only moves on a handshake, so it holds through stalls.
            if (axi.axi_slv_rready) begin
               if (rbeat_q.last) begin
                  state_d  = ST_IDLE;
                  rvalid_d = 1'b0;
                  rbeat_d  = '0;
               end else begin
                  addr_d  = addr_nxt;
                  beat_d  = beat_nxt;
                  rbeat_d = make_beat(addr_nxt, beat_nxt, len_q, err_q);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rbeat_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         size_q   <= size_d;
         burst_q  <= burst_d;
         beat_q   <= beat_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
         rbeat_q  <= rbeat_d;
      end
   end

   // Ready is not looked ahead: a full queue refuses even when popping.
   assign axi.axi_slv_arready = ~fifo_full;
   assign axi.axi_slv_rvalid  = rvalid_q;
   assign axi.axi_slv_rid     = id_q;
   assign axi.axi_slv_rdata   = rbeat_q.data;
   assign axi.axi_slv_rresp   = rbeat_q.resp;
   assign axi.axi_slv_rlast   = rbeat_q.last;

endmodule
